// File: rtl/hs_pipe.sv
// hs_pipe: cascade of STAGES skid-buffer stages with valid/ready handshakes on both sides.
//   Each stage holds a main and a skid register, so total capacity is 2*STAGES beats.
//   Every stage's ready comes straight from a flop, so there is no combinational path
//   from m_ready back to s_ready or from s_valid forward to m_valid.
//
// Optional feature: define HS_PIPE_FLUSH_EN to add the `flush` input. Flush is a
//   synchronous drop of every held beat; data registers are left untouched.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   s_valid    upstream beat valid
//   s_ready    pipe can take the upstream beat (0 while rst=1)
//   s_data     upstream payload
//   m_valid    downstream beat valid
//   m_ready    downstream can take the beat
//   m_data     downstream payload; holds its last value while m_valid=0
//   occupancy  number of beats currently held (0..2*STAGES)
//   flush      (HS_PIPE_FLUSH_EN only) drop all held beats at the next edge
module hs_pipe #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned STAGES     = 2,
   localparam int unsigned OCC_W     = $clog2(2 * STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef HS_PIPE_FLUSH_EN
   input  logic                  flush,
`endif
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [OCC_W-1:0]      occupancy
);

   logic [STAGES-1:0]     main_valid_q, main_valid_d;
   logic [STAGES-1:0]     skid_valid_q, skid_valid_d;
   logic [DATA_WIDTH-1:0] main_data_q [STAGES];
   logic [DATA_WIDTH-1:0] main_data_d [STAGES];
   logic [DATA_WIDTH-1:0] skid_data_q [STAGES];
   logic [DATA_WIDTH-1:0] skid_data_d [STAGES];
   logic [OCC_W-1:0]      occ_q, occ_d;

   logic [STAGES-1:0]     in_valid;
   logic [STAGES-1:0]     out_ready;
   logic [STAGES-1:0]     in_xfer;
   logic [STAGES-1:0]     out_xfer;
   logic [DATA_WIDTH-1:0] in_data [STAGES];

   logic flush_w;
   logic s_xfer;
   logic m_xfer;

`ifdef HS_PIPE_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // Stage chaining: stage k input is stage k-1 output; stage k output ready is stage k+1 ready.
   for (genvar k = 0; k < STAGES; k++) begin : g_chain
      if (k == 0) begin : g_first
         assign in_valid[k] = s_valid;
         assign in_data[k]  = s_data;
      end else begin : g_mid_in
         assign in_valid[k] = main_valid_q[k-1];
         assign in_data[k]  = main_data_q[k-1];
      end
      if (k == STAGES - 1) begin : g_last
         assign out_ready[k] = m_ready;
      end else begin : g_mid_out
         assign out_ready[k] = ~skid_valid_q[k+1];
      end
      // A stage is ready exactly when its skid register is empty.
      assign in_xfer[k]  = in_valid[k] & ~skid_valid_q[k];
      assign out_xfer[k] = main_valid_q[k] & out_ready[k];
   end

   // Reset gates s_ready so nothing is reported as accepted during reset.
   assign s_ready   = ~skid_valid_q[0] & ~rst;
   assign m_valid   = main_valid_q[STAGES-1];
   assign m_data    = main_data_q[STAGES-1];
   assign occupancy = occ_q;
   assign s_xfer    = s_valid & s_ready;
   assign m_xfer    = m_valid & m_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      for (int k = 0; k < STAGES; k++) begin
         if (out_xfer[k]) begin
            if (skid_valid_q[k]) begin
               main_data_d[k]  = skid_data_q[k];
               skid_valid_d[k] = 1'b0;
            end else if (in_xfer[k]) begin
               main_data_d[k] = in_data[k];
            end else begin
               main_valid_d[k] = 1'b0;
            end
         end else if (in_xfer[k]) begin
            if (!main_valid_q[k]) begin
               main_valid_d[k] = 1'b1;
               main_data_d[k]  = in_data[k];
            end else begin
               skid_valid_d[k] = 1'b1;
               skid_data_d[k]  = in_data[k];
            end
         end
      end
      // Flush wins over any same-cycle transfer but keeps the data registers.
      if (flush_w) begin
         main_valid_d = '0;
         skid_valid_d = '0;
      end
   end

   always_comb begin
      occ_d = occ_q;
      unique case ({s_xfer, m_xfer})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      if (flush_w) begin
         occ_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= '0;
         skid_valid_q <= '0;
         occ_q        <= '0;
         for (int k = 0; k < STAGES; k++) begin
            main_data_q[k] <= '0;
            skid_data_q[k] <= '0;
         end
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         occ_q        <= occ_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: tb/tb_hs_pipe.sv
// Bench for hs_pipe: three instances (STAGES=2, 1, 8) share one stimulus.
// Directed scenarios check the STAGES=2 instance; the random scenario checks STAGES=1 and 8.
module tb_hs_pipe;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        s_valid;
   logic [15:0] s_data;
   logic        m_ready;

   logic        s_ready_2, m_valid_2;
   logic [15:0] m_data_2;
   logic [2:0]  occ_2;
   logic        s_ready_1, m_valid_1;
   logic [15:0] m_data_1;
   logic [1:0]  occ_1;
   logic        s_ready_8, m_valid_8;
   logic [15:0] m_data_8;
   logic [4:0]  occ_8;

   int n_checks = 0;
   int n_fail   = 0;

   hs_pipe #(.DATA_WIDTH(16), .STAGES(2)) dut2 (
      .clk(clk), .rst(rst),
`ifdef HS_PIPE_FLUSH_EN
      .flush(flush),
`endif
      .s_valid(s_valid), .s_ready(s_ready_2), .s_data(s_data),
      .m_valid(m_valid_2), .m_ready(m_ready), .m_data(m_data_2), .occupancy(occ_2)
   );

   hs_pipe #(.DATA_WIDTH(16), .STAGES(1)) dut1 (
      .clk(clk), .rst(rst),
`ifdef HS_PIPE_FLUSH_EN
      .flush(flush),
`endif
      .s_valid(s_valid), .s_ready(s_ready_1), .s_data(s_data),
      .m_valid(m_valid_1), .m_ready(m_ready), .m_data(m_data_1), .occupancy(occ_1)
   );

   hs_pipe #(.DATA_WIDTH(16), .STAGES(8)) dut8 (
      .clk(clk), .rst(rst),
`ifdef HS_PIPE_FLUSH_EN
      .flush(flush),
`endif
      .s_valid(s_valid), .s_ready(s_ready_8), .s_data(s_data),
      .m_valid(m_valid_8), .m_ready(m_ready), .m_data(m_data_8), .occupancy(occ_8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      flush   = 1'b0;
      s_valid = 1'b0;
      s_data  = 16'h0000;
      m_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      flush   = 1'b0;
      s_valid = 1'b1;
      s_data  = 16'h1234;
      m_ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if (s_ready_2 !== 1'b0) begin
         $display("FAIL reset_s_ready_low: got %b want 0", s_ready_2); n_fail++;
      end
      n_checks++;
      if (occ_2 !== 3'd0) begin
         $display("FAIL reset_ignores_s_valid: occupancy got %0d want 0", occ_2); n_fail++;
      end
      rst     = 1'b0;
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (s_ready_2 !== 1'b1) begin
         $display("FAIL post_reset_s_ready: got %b want 1", s_ready_2); n_fail++;
      end
      n_checks++;
      if (m_valid_2 !== 1'b0) begin
         $display("FAIL post_reset_m_valid: got %b want 0", m_valid_2); n_fail++;
      end
      n_checks++;
      if (occ_2 !== 3'd0) begin
         $display("FAIL post_reset_occupancy: got %0d want 0", occ_2); n_fail++;
      end
      n_checks++;
      if (m_data_2 !== 16'h0000) begin
         $display("FAIL post_reset_m_data: got %h want 0000", m_data_2); n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      do_reset();
      m_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         s_valid = (c < 16);
         s_data  = 16'(c + 1);
         #1;
         exp_v = (c >= 2 && c <= 17);
         n_checks++;
         if (m_valid_2 !== exp_v) begin
            $display("FAIL b2b_m_valid cycle %0d: got %b want %b", c, m_valid_2, exp_v);
            n_fail++;
         end
         if (exp_v) begin
            n_checks++;
            if (m_data_2 !== 16'(c - 1)) begin
               $display("FAIL b2b_m_data cycle %0d: got %h want %h", c, m_data_2, 16'(c - 1));
               n_fail++;
            end
         end
         if (c < 16) begin
            n_checks++;
            if (s_ready_2 !== 1'b1) begin
               $display("FAIL b2b_s_ready cycle %0d: got %b want 1", c, s_ready_2);
               n_fail++;
            end
         end
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic test_full();
      int acc;
      do_reset();
      m_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         s_valid = 1'b1;
         s_data  = 16'(acc + 1);
         #1;
         if (s_ready_2 === 1'b1) acc++;
         tick();
      end
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (acc != 4) begin
         $display("FAIL full_accept_count: got %0d want 4", acc); n_fail++;
      end
      n_checks++;
      if (s_ready_2 !== 1'b0) begin
         $display("FAIL full_s_ready: got %b want 0", s_ready_2); n_fail++;
      end
      n_checks++;
      if (occ_2 !== 3'd4) begin
         $display("FAIL full_occupancy: got %0d want 4", occ_2); n_fail++;
      end
      n_checks++;
      if (m_valid_2 !== 1'b1 || m_data_2 !== 16'h0001) begin
         $display("FAIL full_head: got v=%b d=%h want v=1 d=0001", m_valid_2, m_data_2);
         n_fail++;
      end
      m_ready = 1'b1;
      #1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (m_valid_2 !== 1'b1 || m_data_2 !== 16'(k)) begin
            $display("FAIL full_drain beat %0d: got v=%b d=%h want v=1 d=%h",
                     k, m_valid_2, m_data_2, 16'(k));
            n_fail++;
         end
         if (k >= 3) begin
            n_checks++;
            if (s_ready_2 !== 1'b1) begin
               $display("FAIL full_s_ready_return beat %0d: got %b want 1", k, s_ready_2);
               n_fail++;
            end
         end
         tick();
      end
      n_checks++;
      if (m_valid_2 !== 1'b0 || occ_2 !== 3'd0) begin
         $display("FAIL full_empty_after_drain: got v=%b occ=%0d want v=0 occ=0",
                  m_valid_2, occ_2);
         n_fail++;
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = 16'h00A1 + 16'(i);
         tick();
      end
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (occ_2 !== 3'd3) begin
         $display("FAIL midreset_pre_occupancy: got %0d want 3", occ_2); n_fail++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (occ_2 !== 3'd0 || m_valid_2 !== 1'b0 || s_ready_2 !== 1'b1) begin
         $display("FAIL midreset_state: got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1",
                  occ_2, m_valid_2, s_ready_2);
         n_fail++;
      end
      m_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         n_checks++;
         if (m_valid_2 !== 1'b0) begin
            $display("FAIL midreset_stale_beat cycle %0d: got v=%b d=%h want v=0",
                     c, m_valid_2, m_data_2);
            n_fail++;
         end
         tick();
      end
      m_ready = 1'b0;
   endtask

`ifdef HS_PIPE_FLUSH_EN
   task automatic test_flush();
      logic exp_v;
      do_reset();
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 16'h0011;
      tick();
      s_data  = 16'h0022;
      tick();
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (occ_2 !== 3'd2) begin
         $display("FAIL flush_pre_occupancy: got %0d want 2", occ_2); n_fail++;
      end
      flush   = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'hBEEF;
      m_ready = 1'b1;
      #1;
      n_checks++;
      if (s_ready_2 !== 1'b1) begin
         $display("FAIL flush_s_ready_during: got %b want 1", s_ready_2); n_fail++;
      end
      tick();
      flush   = 1'b0;
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (occ_2 !== 3'd0 || m_valid_2 !== 1'b0 || s_ready_2 !== 1'b1) begin
         $display("FAIL flush_state: got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1",
                  occ_2, m_valid_2, s_ready_2);
         n_fail++;
      end
      s_valid = 1'b1;
      s_data  = 16'h0042;
      tick();
      s_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         #1;
         exp_v = (c == 2);
         n_checks++;
         if (m_valid_2 !== exp_v || (exp_v && m_data_2 !== 16'h0042)) begin
            $display("FAIL flush_next_beat cycle %0d: got v=%b d=%h want v=%b d=0042",
                     c, m_valid_2, m_data_2, exp_v);
            n_fail++;
         end
         tick();
      end
      m_ready = 1'b0;
   endtask
`endif

   task automatic test_random();
      logic [15:0] q1[$];
      logic [15:0] q8[$];
      logic [15:0] exp_d;
      logic        sr1, mv1, sr8, mv8;
      logic [15:0] md1, md8, prev_md1, prev_md8;
      logic        stall1, stall8;
      do_reset();
      stall1   = 1'b0;
      stall8   = 1'b0;
      prev_md1 = '0;
      prev_md8 = '0;
      for (int n = 0; n < 10000; n++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = 16'($urandom);
         m_ready = 1'($urandom_range(0, 1));
         #1;
         sr1 = s_ready_1; mv1 = m_valid_1; md1 = m_data_1;
         sr8 = s_ready_8; mv8 = m_valid_8; md8 = m_data_8;
         if (stall1) begin
            n_checks++;
            if (mv1 !== 1'b1 || md1 !== prev_md1) begin
               $display("FAIL rand1_stall cycle %0d: got v=%b d=%h want v=1 d=%h",
                        n, mv1, md1, prev_md1);
               n_fail++;
            end
         end
         if (stall8) begin
            n_checks++;
            if (mv8 !== 1'b1 || md8 !== prev_md8) begin
               $display("FAIL rand8_stall cycle %0d: got v=%b d=%h want v=1 d=%h",
                        n, mv8, md8, prev_md8);
               n_fail++;
            end
         end
         tick();
         if (mv1 === 1'b1 && m_ready) begin
            exp_d = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
            n_checks++;
            if (md1 !== exp_d) begin
               $display("FAIL rand1_data cycle %0d: got %h want %h", n, md1, exp_d);
               n_fail++;
            end
         end
         if (mv8 === 1'b1 && m_ready) begin
            exp_d = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
            n_checks++;
            if (md8 !== exp_d) begin
               $display("FAIL rand8_data cycle %0d: got %h want %h", n, md8, exp_d);
               n_fail++;
            end
         end
         if (s_valid && sr1 === 1'b1) q1.push_back(s_data);
         if (s_valid && sr8 === 1'b1) q8.push_back(s_data);
         n_checks++;
         if (int'(occ_1) != q1.size()) begin
            $display("FAIL rand1_occupancy cycle %0d: got %0d want %0d", n, occ_1, q1.size());
            n_fail++;
         end
         n_checks++;
         if (int'(occ_8) != q8.size()) begin
            $display("FAIL rand8_occupancy cycle %0d: got %0d want %0d", n, occ_8, q8.size());
            n_fail++;
         end
         stall1   = mv1 && !m_ready;
         stall8   = mv8 && !m_ready;
         prev_md1 = md1;
         prev_md8 = md8;
      end
      s_valid = 1'b0;
      m_ready = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      s_valid = 1'b0;
      s_data  = 16'h0000;
      m_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_full();
      test_reset_mid();
`ifdef HS_PIPE_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
